// File: rtl/port_array_queue.sv
// port_array_queue: an array of nports independent flop-based FIFOs, each ndepth entries
// deep and nbits wide, with val/rdy handshakes on both the enqueue and dequeue sides.
//
// Optional feature: define PORT_ARRAY_QUEUE_BYPASS_EN to add a zero-latency path. On an
// empty channel, an incoming message is then presented on the dequeue side in the same
// cycle. In the default build there is no such path, and enq_rdy, deq_val and count come
// straight from registers.
module port_array_queue #(
  parameter int unsigned nports = 2,
  parameter int unsigned nbits  = 32,
  parameter int unsigned ndepth = 4
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [nports-1:0]                            enq_val,
  output logic [nports-1:0]                            enq_rdy,
  input  logic [nports-1:0][nbits-1:0]                 enq_msg,
  output logic [nports-1:0]                            deq_val,
  input  logic [nports-1:0]                            deq_rdy,
  output logic [nports-1:0][nbits-1:0]                 deq_msg,
  output logic [nports-1:0][$clog2(ndepth+1)-1:0]      count
);

  localparam int unsigned CntW = $clog2(ndepth + 1);
  localparam int unsigned PtrW = $clog2(ndepth);

  for (genvar i = 0; i < nports; i++) begin : g_chan
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [nbits-1:0] mem_q [ndepth];

    logic             full;
    logic             empty;
    logic             chan_deq_val;
    logic [nbits-1:0] chan_deq_msg;
    logic             enq_fire;
    logic             deq_fire;
    logic             pass_thru;
    logic             do_write;
    logic             do_read;

    assign full  = (count_q == CntW'(ndepth));
    assign empty = (count_q == '0);

`ifdef PORT_ARRAY_QUEUE_BYPASS_EN
    // An empty channel forwards the incoming message straight to the dequeue side.
    assign chan_deq_val = !empty || enq_val[i];
    assign chan_deq_msg = empty ? enq_msg[i] : mem_q[rd_ptr_q];
    // Both sides handshake on an empty channel: the message never touches storage.
    assign pass_thru    = empty && enq_val[i] && deq_rdy[i];
`else
    assign chan_deq_val = !empty;
    assign chan_deq_msg = mem_q[rd_ptr_q];
    assign pass_thru    = 1'b0;
`endif

    // A full channel refuses enqueue even when a dequeue happens in the same cycle.
    assign enq_fire = enq_val[i] && !full;
    assign deq_fire = chan_deq_val && deq_rdy[i];
    assign do_write = enq_fire && !pass_thru;
    assign do_read  = deq_fire && !pass_thru;

    // Next-state for the pointers and the occupancy count.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_write) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_read) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({do_write, do_read})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end

    // Pointer and count registers; reset empties the channel and discards its contents.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Payload storage; entries are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
      if (do_write) begin
        mem_q[wr_ptr_q] <= enq_msg[i];
      end
    end

    assign enq_rdy[i] = !full;
    assign deq_val[i] = chan_deq_val;
    assign deq_msg[i] = chan_deq_msg;
    assign count[i]   = count_q;
  end

endmodule

// File: tb/tb_port_array_queue.sv
// Self-checking bench for port_array_queue: directed vectors on a 2x32x4 instance and a
// randomised scoreboard run on a 3x8x4 instance. Honours PORT_ARRAY_QUEUE_BYPASS_EN.
module tb_port_array_queue;

  logic clk;
  logic reset_n;

  // Instance A: default parameters.
  logic [1:0]        enq_val_a, enq_rdy_a, deq_val_a, deq_rdy_a;
  logic [1:0][31:0]  enq_msg_a, deq_msg_a;
  logic [1:0][2:0]   count_a;

  // Instance B: nports=3, nbits=8.
  logic [2:0]        enq_val_b, enq_rdy_b, deq_val_b, deq_rdy_b;
  logic [2:0][7:0]   enq_msg_b, deq_msg_b;
  logic [2:0][2:0]   count_b;

  int n_checks;
  int n_fail;

  logic [7:0] sb_q [3][$];

  port_array_queue #(.nports(2), .nbits(32), .ndepth(4)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .enq_val (enq_val_a),
    .enq_rdy (enq_rdy_a),
    .enq_msg (enq_msg_a),
    .deq_val (deq_val_a),
    .deq_rdy (deq_rdy_a),
    .deq_msg (deq_msg_a),
    .count   (count_a)
  );

  port_array_queue #(.nports(3), .nbits(8), .ndepth(4)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .enq_val (enq_val_b),
    .enq_rdy (enq_rdy_b),
    .enq_msg (enq_msg_b),
    .deq_val (deq_val_b),
    .deq_rdy (deq_rdy_b),
    .deq_msg (deq_msg_b),
    .count   (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are changed and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e0 [3];
    logic [31:0] e1 [3];
    int          sz;
    logic        exp_dv;
    n_checks = 0;
    n_fail   = 0;
    e0 = '{32'h11, 32'h22, 32'h33};
    e1 = '{32'hA1, 32'hA2, 32'hA3};

    // Reset with active-looking inputs that must be ignored.
    reset_n   = 1'b0;
    enq_val_a = 2'b11;
    deq_rdy_a = 2'b11;
    enq_msg_a = '{32'hDEAD, 32'hBEEF};
    enq_val_b = '0;
    deq_rdy_b = '0;
    enq_msg_b = '0;
    tick();
    tick();
    check_eq("rst_count", 64'(count_a), 64'h0);
    check_eq("rst_enq_rdy", 64'(enq_rdy_a), 64'h3);
    enq_val_a = '0;
    deq_rdy_a = '0;
    #1;
    check_eq("rst_deq_val", 64'(deq_val_a), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Three enqueues on port 0, no dequeue.
    enq_val_a = 2'b01;
    for (int k = 0; k < 3; k++) begin
      enq_msg_a[0] = e0[k];
      tick();
    end
    enq_val_a = '0;
    #1;
    check_eq("fill0_count0", 64'(count_a[0]), 64'd3);
    check_eq("fill0_msg0", 64'(deq_msg_a[0]), 64'h11);
    check_eq("fill0_count1", 64'(count_a[1]), 64'd0);
    check_eq("fill0_deq_val", 64'(deq_val_a), 64'h1);

    // Fill port 1 completely.
    enq_val_a = 2'b10;
    for (int k = 0; k < 4; k++) begin
      enq_msg_a[1] = 32'hA0 + 32'(k);
      tick();
    end
    enq_val_a = '0;
    #1;
    check_eq("full1_count", 64'(count_a[1]), 64'd4);
    check_eq("full1_enq_rdy", 64'(enq_rdy_a), 64'h1);

    // Enqueue and dequeue together on a full channel: dequeue only.
    enq_val_a    = 2'b10;
    deq_rdy_a    = 2'b10;
    enq_msg_a[1] = 32'hFF;
    tick();
    enq_val_a = '0;
    deq_rdy_a = '0;
    #1;
    check_eq("full1_deq_count", 64'(count_a[1]), 64'd3);
    check_eq("full1_deq_head", 64'(deq_msg_a[1]), 64'hA1);
    check_eq("full1_deq_rdy", 64'(enq_rdy_a), 64'h3);

    // Drain both ports in order.
    deq_rdy_a = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("drain0", 64'(deq_msg_a[0]), 64'(e0[k]));
      check_eq("drain1", 64'(deq_msg_a[1]), 64'(e1[k]));
      tick();
    end
    check_eq("drain_count", 64'(count_a), 64'h0);
    check_eq("drain_deq_val", 64'(deq_val_a), 64'h0);

    // Stream 10 words on both ports with both sides always active.
    enq_val_a = 2'b11;
    deq_rdy_a = 2'b11;
    for (int k = 0; k < 10; k++) begin
      enq_msg_a[0] = 32'(k);
      enq_msg_a[1] = 32'h10 + 32'(k);
      #1;
`ifdef PORT_ARRAY_QUEUE_BYPASS_EN
      check_eq("stream_msg0", 64'(deq_msg_a[0]), 64'(k));
      check_eq("stream_msg1", 64'(deq_msg_a[1]), 64'(32'h10 + 32'(k)));
      check_eq("stream_count", 64'(count_a), 64'h0);
`else
      if (k > 0) begin
        check_eq("stream_msg0", 64'(deq_msg_a[0]), 64'(k - 1));
        check_eq("stream_msg1", 64'(deq_msg_a[1]), 64'(32'h10 + 32'(k - 1)));
        check_eq("stream_count", 64'(count_a), {58'h0, 3'd1, 3'd1});
      end
`endif
      tick();
    end
    enq_val_a = '0;
    #1;
`ifndef PORT_ARRAY_QUEUE_BYPASS_EN
    check_eq("stream_last0", 64'(deq_msg_a[0]), 64'h9);
    check_eq("stream_last1", 64'(deq_msg_a[1]), 64'h19);
    tick();
`endif
    deq_rdy_a = '0;
    #1;
    check_eq("stream_end_count", 64'(count_a), 64'h0);

    // Asynchronous reset mid-operation.
    enq_val_a    = 2'b01;
    enq_msg_a[0] = 32'hAA;
    tick();
    enq_msg_a[0] = 32'hBB;
    tick();
    enq_val_a = '0;
    #1;
    check_eq("pre_rst_count", 64'(count_a[0]), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_count", 64'(count_a), 64'h0);
    check_eq("async_rst_deq_val", 64'(deq_val_a), 64'h0);
    check_eq("async_rst_enq_rdy", 64'(enq_rdy_a), 64'h3);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    enq_val_a    = 2'b01;
    enq_msg_a[0] = 32'hCC;
    tick();
    enq_val_a = '0;
    #1;
    check_eq("post_rst_msg", 64'(deq_msg_a[0]), 64'hCC);
    check_eq("post_rst_count", 64'(count_a[0]), 64'd1);
    deq_rdy_a = 2'b01;
    tick();
    deq_rdy_a = '0;
    #1;
    check_eq("post_rst_drain", 64'(count_a[0]), 64'd0);

    // Bypass behaviour (or its absence) on an empty channel.
    enq_val_a    = 2'b01;
    deq_rdy_a    = 2'b01;
    enq_msg_a[0] = 32'h5A;
    #1;
`ifdef PORT_ARRAY_QUEUE_BYPASS_EN
    check_eq("byp_deq_val", 64'(deq_val_a[0]), 64'h1);
    check_eq("byp_deq_msg", 64'(deq_msg_a[0]), 64'h5A);
    tick();
    enq_val_a = '0;
    deq_rdy_a = '0;
    #1;
    check_eq("byp_count", 64'(count_a[0]), 64'd0);
`else
    check_eq("nobyp_deq_val0", 64'(deq_val_a[0]), 64'h0);
    tick();
    enq_val_a = '0;
    #1;
    check_eq("nobyp_deq_val1", 64'(deq_val_a[0]), 64'h1);
    check_eq("nobyp_deq_msg", 64'(deq_msg_a[0]), 64'h5A);
    check_eq("nobyp_count", 64'(count_a[0]), 64'd1);
    tick();
    deq_rdy_a = '0;
    #1;
    check_eq("nobyp_drain", 64'(count_a[0]), 64'd0);
`endif

    // Random independent traffic on instance B against a per-port scoreboard.
    for (int c = 0; c < 1000; c++) begin
      enq_val_b = 3'($urandom);
      deq_rdy_b = 3'($urandom);
      enq_msg_b = 24'($urandom);
      #1;
      for (int p = 0; p < 3; p++) begin
        sz = sb_q[p].size();
        check_eq("rnd_count", 64'(count_b[p]), 64'(sz));
        check_eq("rnd_enq_rdy", 64'(enq_rdy_b[p]), 64'(sz != 4));
`ifdef PORT_ARRAY_QUEUE_BYPASS_EN
        exp_dv = (sz != 0) || enq_val_b[p];
`else
        exp_dv = (sz != 0);
`endif
        check_eq("rnd_deq_val", 64'(deq_val_b[p]), 64'(exp_dv));
        if (enq_val_b[p] && sz != 4) sb_q[p].push_back(enq_msg_b[p]);
        if (exp_dv && deq_rdy_b[p] && sb_q[p].size() != 0) begin
          check_eq("rnd_deq_msg", 64'(deq_msg_b[p]), 64'(sb_q[p].pop_front()));
        end
      end
      tick();
    end

    // Drain instance B and confirm nothing was lost or duplicated.
    enq_val_b = '0;
    deq_rdy_b = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int p = 0; p < 3; p++) begin
        if (sb_q[p].size() != 0) begin
          check_eq("rnd_drain_val", 64'(deq_val_b[p]), 64'h1);
          check_eq("rnd_drain_msg", 64'(deq_msg_b[p]), 64'(sb_q[p].pop_front()));
        end
      end
      tick();
    end
    for (int p = 0; p < 3; p++) begin
      check_eq("rnd_final_sb", 64'(sb_q[p].size()), 64'h0);
    end
    check_eq("rnd_final_count", 64'(count_b), 64'h0);
    check_eq("rnd_final_deq_val", 64'(deq_val_b), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
